dmem_port_arbiter: RTL
======================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single-port data memory between the CPU MEM stage and a debug/DMA port
//  (memory preload and dump). Grants one access per cycle and stalls the pipeline while
//  the debug port owns memory. Bounded bursts keep either requester from starving.
//  Sits between the cpu MEM stage, the hazard/stall logic and the data memory.
// PARAMETERS
//  ADDR_W     5   word-address width (32 words)
//  DATA_W     32  data width
//  MAX_BURST  4   max consecutive grants to one owner while the other requester waits (>=1)
// PORTS
//  clock      in   1       system clock, all state updates on posedge
//  reset      in   1       synchronous, active-low reset (0 = reset)
//  cpu_req    in   1       CPU MEM-stage access request (MemRead|MemWrite)
//  cpu_we     in   1       1 = store, 0 = load
//  cpu_addr   in   ADDR_W  CPU word address
//  cpu_wdata  in   DATA_W  CPU store data
//  cpu_stall  out  1       cpu_req held but not granted this cycle; freezes the pipeline
//  cpu_rvalid out  1       load data valid on cpu_rdata (1 cycle after the load grant)
//  cpu_rdata  out  DATA_W  CPU load data
//  dbg_req    in   1       debug/DMA request, held until dbg_ack
//  dbg_we     in   1       1 = write, 0 = read
//  dbg_addr   in   ADDR_W  debug word address
//  dbg_wdata  in   DATA_W  debug write data
//  dbg_ack    out  1       debug access granted this cycle
//  dbg_rvalid out  1       read data valid on dbg_rdata (1 cycle after the read grant)
//  dbg_rdata  out  DATA_W  debug read data
//  mem_en     out  1       memory access strobe
//  mem_we     out  1       memory write enable
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data (synchronous, valid 1 cycle after mem_en & !mem_we)
// BEHAVIOUR
//  - FSM states: IDLE, OWN_CPU, OWN_DBG; burst_cnt is a saturating counter of grants to the current owner.
//  - Grant is combinational from the state and the requests; mem_* reflect the granted requester in the same cycle.
//  - IDLE: if cpu_req, grant the CPU and go to OWN_CPU; otherwise, if dbg_req, grant debug and go to OWN_DBG.
//    If both request, the CPU wins.
//  - OWN_x: keep the owner while it requests, unless burst_cnt==MAX_BURST and the other side requests;
//    then grant the other side, switch state and set burst_cnt=1. Owner idle and other requests -> switch.
//    Neither requests -> IDLE with burst_cnt=0.
//  - Each grant increments burst_cnt; a switch sets it to 1.
//  - cpu_stall = cpu_req & ~cpu_grant. dbg_ack = dbg_grant. No grant -> mem_en=0, mem_we=0, addr/wdata=0.
//  - Read return: a registered flag routes mem_rdata to the requester of the previous cycle's read.
//    cpu_rvalid/dbg_rvalid pulse for 1 cycle. The rdata registers hold their last value.
//  - Write: completes in the grant cycle; no rvalid pulse.
//  - Reset (reset==0 at posedge): state=IDLE, burst_cnt=0, cpu_rvalid=dbg_rvalid=0, cpu_rdata=dbg_rdata=0.
//    A reset during a pending read suppresses its rvalid. cpu_stall and dbg_ack are 0 while reset is low.
//  - MAX_BURST=1 gives strict alternation under continuous contention.
// CONFIGURATION
//  ARB_STATS_EN defined:
//    - adds ports stat_cpu_grants, stat_dbg_grants, stat_stall_cycles (16 bits each).
//    - Counters are saturating, cleared by reset, and increment on cpu grant, dbg grant and cpu_stall respectively.
//  ARB_STATS_EN undefined: the ports and counters are absent; arbitration is identical.
// TESTING
//  - CPU only: load addr 3 (mem[3]=42) -> mem_en=1 same cycle; cpu_rvalid=1, cpu_rdata=42 next cycle; cpu_stall=0.
//  - Debug only: dbg write addr 7 = 99, then read addr 7 -> dbg_ack each cycle; dbg_rvalid with 99 one cycle after the read.
//  - Same-cycle request from IDLE (cpu store addr 1, dbg read addr 2) -> CPU granted, dbg_ack=0;
//    dbg granted next cycle when the CPU drops its request.
//  - Continuous contention, MAX_BURST=4:
//    - grant sequence C,C,C,C,D,D,D,D,C...
//    - cpu_stall=1 exactly during the D cycles; no starvation over 40 cycles.
//  - Reset low for 1 cycle while a CPU load is in flight -> cpu_rvalid stays 0, state IDLE,
//    next cpu_req is granted immediately.
//  - ARB_STATS_EN: 10 CPU grants + 3 stalls -> stat_cpu_grants=10, stat_stall_cycles=3;
//    counters stick at 0xFFFF after saturation.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data memory between the CPU MEM stage and a debug/DMA port.
// Optional ARB_STATS_EN adds saturating grant/stall statistics counters.
module dmem_port_arbiter #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]       stat_cpu_grants,
    output logic [15:0]       stat_dbg_grants,
    output logic [15:0]       stat_stall_cycles
`endif
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_CPU = 2'd1,
        OWN_DBG = 2'd2
    } state_t;

    state_t              state_r;
    logic [CNT_W-1:0]    burst_cnt_r;
    logic                cpu_grant_s;
    logic                dbg_grant_s;
    logic                burst_full_s;
    logic                cpu_rd_r;
    logic                dbg_rd_r;
    logic [DATA_W-1:0]   cpu_rdata_r;
    logic [DATA_W-1:0]   dbg_rdata_r;

    // Grant decision: owner keeps memory unless its burst is spent and the other side waits.
    always_comb begin
        cpu_grant_s  = 1'b0;
        dbg_grant_s  = 1'b0;
        burst_full_s = (burst_cnt_r == BURST_MAX);
        if (reset) begin
            case (state_r)
                IDLE: begin
                    if (cpu_req) begin
                        cpu_grant_s = 1'b1;
                    end else if (dbg_req) begin
                        dbg_grant_s = 1'b1;
                    end else begin
                        cpu_grant_s = 1'b0;
                    end
                end
                OWN_CPU: begin
                    if (cpu_req && !(burst_full_s && dbg_req)) begin
                        cpu_grant_s = 1'b1;
                    end else if (dbg_req) begin
                        dbg_grant_s = 1'b1;
                    end else begin
                        cpu_grant_s = 1'b0;
                    end
                end
                OWN_DBG: begin
                    if (dbg_req && !(burst_full_s && cpu_req)) begin
                        dbg_grant_s = 1'b1;
                    end else if (cpu_req) begin
                        cpu_grant_s = 1'b1;
                    end else begin
                        dbg_grant_s = 1'b0;
                    end
                end
                default: begin
                    cpu_grant_s = 1'b0;
                    dbg_grant_s = 1'b0;
                end
            endcase
        end else begin
            cpu_grant_s = 1'b0;
            dbg_grant_s = 1'b0;
        end
    end

    // Ownership state and saturating burst counter.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r     <= IDLE;
            burst_cnt_r <= '0;
        end else if (cpu_grant_s) begin
            state_r     <= OWN_CPU;
            if (state_r == OWN_CPU) begin
                burst_cnt_r <= burst_full_s ? burst_cnt_r : burst_cnt_r + CNT_W'(1);
            end else begin
                burst_cnt_r <= CNT_W'(1);
            end
        end else if (dbg_grant_s) begin
            state_r     <= OWN_DBG;
            if (state_r == OWN_DBG) begin
                burst_cnt_r <= burst_full_s ? burst_cnt_r : burst_cnt_r + CNT_W'(1);
            end else begin
                burst_cnt_r <= CNT_W'(1);
            end
        end else begin
            state_r     <= IDLE;
            burst_cnt_r <= '0;
        end
    end

    // Memory request mux; an ungranted cycle drives an all-zero request.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_grant_s) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dbg_grant_s) begin
            mem_en    = 1'b1;
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end else begin
            mem_en    = 1'b0;
        end
    end

    // Read-return routing flags and held copies of the last returned data.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cpu_rd_r    <= 1'b0;
            dbg_rd_r    <= 1'b0;
            cpu_rdata_r <= '0;
            dbg_rdata_r <= '0;
        end else begin
            cpu_rd_r <= cpu_grant_s & ~cpu_we;
            dbg_rd_r <= dbg_grant_s & ~dbg_we;
            if (cpu_rd_r) begin
                cpu_rdata_r <= mem_rdata;
            end else begin
                cpu_rdata_r <= cpu_rdata_r;
            end
            if (dbg_rd_r) begin
                dbg_rdata_r <= mem_rdata;
            end else begin
                dbg_rdata_r <= dbg_rdata_r;
            end
        end
    end

    // A reset landing on the return cycle swallows the pending read.
    assign cpu_rvalid = cpu_rd_r & reset;
    assign dbg_rvalid = dbg_rd_r & reset;
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_r;
    assign dbg_rdata  = dbg_rvalid ? mem_rdata : dbg_rdata_r;
    assign cpu_stall  = cpu_req & ~cpu_grant_s & reset;
    assign dbg_ack    = dbg_grant_s;

`ifdef ARB_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] val, input logic hit);
        if (hit && (val != 16'hFFFF)) begin
            return val + 16'd1;
        end else begin
            return val;
        end
    endfunction

    // Saturating event counters.
    always_ff @(posedge clock) begin
        if (!reset) begin
            stat_cpu_grants   <= 16'd0;
            stat_dbg_grants   <= 16'd0;
            stat_stall_cycles <= 16'd0;
        end else begin
            stat_cpu_grants   <= sat_inc16(stat_cpu_grants, cpu_grant_s);
            stat_dbg_grants   <= sat_inc16(stat_dbg_grants, dbg_grant_s);
            stat_stall_cycles <= sat_inc16(stat_stall_cycles, cpu_stall);
        end
    end
`endif

endmodule
